vec_sub_pipe_hs: RTL and testbench

//  Parametrised successor to the fixed 32-lane 6-bit vector subtractor.

---
 rtl/vec_sub_pipe_hs.sv | 200 ++++++++++++++++++++
 tb/tb_vec_sub_pipe_hs.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sub_pipe_hs.sv
// ---------------------------------------------------------------------------
// vec_sub_pipe_hs
//   Lane-wise signed vector arithmetic on two packed operand vectors, wrapped
//   in a two-stage elastic pipeline with valid/ready handshakes on both sides.
//   Stage 1 registers the operands and mode; stage 2 computes and registers
//   the result and the per-lane overflow flags. A sticky flag collects every
//   overflow that has been handed downstream.
//
//   Build option: define VSUB_SAT_EN to clamp overflowing lanes to MAX/MIN;
//   otherwise overflowing lanes wrap around (low W bits of the exact value).
//
// Parameters
//   W   bits per lane (two's complement, W >= 2)
//   WC  number of lanes
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   in_valid_i    operands/mode valid
//   in_ready_o    block accepts operands this cycle
//   l_i, e_i      operand vectors, lane k = bits [W*k+W-1 : W*k]
//   mode_i        00 L-E, 01 L+E, 10 |L-E|, 11 E-L
//   out_valid_o   result valid
//   out_ready_i   downstream accepts result
//   res_o         result vector, same lane map as the operands
//   ovf_o         per-lane overflow for res_o
//   ovf_sticky_o  OR of all ovf bits transferred since last clear
//   clr_sticky_i  synchronous clear of ovf_sticky_o (a same-cycle set wins)
// ---------------------------------------------------------------------------
module vec_sub_pipe_hs #(
    parameter int W  = 6,
    parameter int WC = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [W*WC-1:0] l_i,
    input  logic [W*WC-1:0] e_i,
    input  logic [1:0]      mode_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [W*WC-1:0] res_o,
    output logic [WC-1:0]   ovf_o,
    output logic            ovf_sticky_o,
    input  logic            clr_sticky_i
);

    localparam int VW = W * WC;

    // Representable lane range, expressed in the W+1 bit exact domain.
    localparam logic signed [W:0] T_MAX = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0] T_MIN = {2'b11, {(W-1){1'b0}}};

    // One lane: returns {overflow, W-bit result}.
    function automatic logic [W:0] lane_op(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0]   m);
        logic signed [W:0] ax;
        logic signed [W:0] bx;
        logic signed [W:0] t;
        logic              of;
        logic [W-1:0]      r;
        ax = {a[W-1], a};
        bx = {b[W-1], b};
        case (m)
            2'b00:   t = ax - bx;
            2'b01:   t = ax + bx;
            2'b10:   t = (ax >= bx) ? (ax - bx) : (bx - ax);
            2'b11:   t = bx - ax;
            default: t = ax - bx;
        endcase
        of = (t > T_MAX) || (t < T_MIN);
`ifdef VSUB_SAT_EN
        if (t > T_MAX) begin
            r = T_MAX[W-1:0];
        end else if (t < T_MIN) begin
            r = T_MIN[W-1:0];
        end else begin
            r = t[W-1:0];
        end
`else
        r = t[W-1:0];
`endif
        return {of, r};
    endfunction

    logic            rdy_q;
    logic            s1_valid_q, s1_valid_d;
    logic [VW-1:0]   l_q, l_d;
    logic [VW-1:0]   e_q, e_d;
    logic [1:0]      mode_q, mode_d;
    logic            out_valid_q, out_valid_d;
    logic [VW-1:0]   res_q, res_d;
    logic [WC-1:0]   ovf_q, ovf_d;
    logic            sticky_q, sticky_d;

    logic            s2_adv_s;
    logic            accept_s;
    logic [VW-1:0]   res_calc_s;
    logic [WC-1:0]   ovf_calc_s;

    // Handshake: stage 1 advances exactly when stage 2 does; rdy_q keeps
    // in_ready low until the first edge after reset release.
    always_comb begin
        s2_adv_s   = !out_valid_q || out_ready_i;
        in_ready_o = rdy_q && (!s1_valid_q || s2_adv_s);
        accept_s   = in_valid_i && in_ready_o;
    end

    // Stage-2 datapath: independent lanes, no carry between them.
    always_comb begin
        logic [W:0] lane_v;
        res_calc_s = '0;
        ovf_calc_s = '0;
        lane_v     = '0;
        for (int k = 0; k < WC; k++) begin
            lane_v = lane_op(l_q[W*k +: W], e_q[W*k +: W], mode_q);
            res_calc_s[W*k +: W] = lane_v[W-1:0];
            ovf_calc_s[k]        = lane_v[W];
        end
    end

    // Next-state logic for both pipeline stages and the sticky flag.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        l_d         = l_q;
        e_d         = e_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        sticky_d    = sticky_q;

        if (accept_s) begin
            s1_valid_d = 1'b1;
            l_d        = l_i;
            e_d        = e_i;
            mode_d     = mode_i;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Result registers only load real data; bubbles leave res/ovf as-is.
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = res_calc_s;
                ovf_d = ovf_calc_s;
            end else begin
                res_d = res_q;
                ovf_d = ovf_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end

        // A set in the same cycle as a clear takes priority.
        if (out_valid_q && out_ready_i && (|ovf_q)) begin
            sticky_d = 1'b1;
        end else if (clr_sticky_i) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State registers; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            l_q         <= '0;
            e_q         <= '0;
            mode_q      <= 2'b00;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            s1_valid_q  <= s1_valid_d;
            l_q         <= l_d;
            e_q         <= e_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign res_o        = res_q;
    assign ovf_o        = ovf_q;
    assign ovf_sticky_o = sticky_q;

endmodule

// File: tb/tb_vec_sub_pipe_hs.sv
module tb_vec_sub_pipe_hs;

    localparam int W  = 6;
    localparam int WC = 4;
    localparam int VW = W * WC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [VW-1:0] l = '0;
    logic [VW-1:0] e = '0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] res;
    logic [WC-1:0] ovf;
    logic          ovf_sticky;
    logic          clr = 1'b0;

    vec_sub_pipe_hs #(.W(W), .WC(WC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .l_i          (l),
        .e_i          (e),
        .mode_i       (mode),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .res_o        (res),
        .ovf_o        (ovf),
        .ovf_sticky_o (ovf_sticky),
        .clr_sticky_i (clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VW-1:0] res;
        logic [WC-1:0] ovf;
    } exp_t;

    exp_t sb[$];
    logic sticky_m = 1'b0;
    int   checks   = 0;
    int   errors   = 0;
    int   acc_cnt  = 0;
    int   out_cnt  = 0;

    // Reference: exact integer arithmetic per lane, then range check.
    function automatic exp_t model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                   input logic [1:0] m);
        exp_t r;
        int x, y, t, v, mx, mn;
        logic [W-1:0] la, lb;
        logic [31:0]  tv;
        mx = (1 << (W-1)) - 1;
        mn = -(1 << (W-1));
        r = '0;
        for (int k = 0; k < WC; k++) begin
            la = a[k*W +: W];
            lb = b[k*W +: W];
            x = int'($signed(la));
            y = int'($signed(lb));
            case (m)
                2'd0: t = x - y;
                2'd1: t = x + y;
                2'd2: t = (x > y) ? x - y : y - x;
                default: t = y - x;
            endcase
            r.ovf[k] = (t > mx) || (t < mn);
`ifdef VSUB_SAT_EN
            v = (t > mx) ? mx : ((t < mn) ? mn : t);
`else
            v = t;
`endif
            tv = v;
            r.res[k*W +: W] = tv[W-1:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample handshakes, advance, update the scoreboard/model.
    task automatic cycle();
        bit ix, ox;
        #1;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        if (out_valid) begin
            chk("out_has_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                chk("res", 64'(res), 64'(sb[0].res));
                chk("ovf", 64'(ovf), 64'(sb[0].ovf));
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (ox && sb.size() > 0 && (|sb[0].ovf)) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        if (ox && sb.size() > 0) begin
            void'(sb.pop_front());
            out_cnt++;
        end
        if (ix) begin
            sb.push_back(model(l, e, mode));
            acc_cnt++;
        end
        chk("sticky", 64'(ovf_sticky), 64'(sticky_m));
    endtask

    task automatic send_one(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [1:0] m);
        l = a; e = b; mode = m; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("latency_not_early", 64'(out_valid), 64'd0);
        cycle();
        chk("latency_two", 64'(out_valid), 64'd1);
    endtask

    initial begin
        logic [5:0] exp_l0;
        int last, stall_acc, out0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("in_ready_after_release", 64'(in_ready), 64'd1);

        // Basic subtract, exact latency
        send_one({6'h1F, 6'h00, 6'h3D, 6'h05}, {6'h00, 6'h00, 6'h04, 6'h03}, 2'b00);
        chk("t1_res_const", 64'(res), 64'h7C0E42);
        chk("t1_ovf_const", 64'(ovf), 64'd0);
        cycle();

        // Negative overflow in lane 0
        send_one({18'h0, 6'h20}, {18'h0, 6'h01}, 2'b00);
`ifdef VSUB_SAT_EN
        exp_l0 = 6'h20;
`else
        exp_l0 = 6'h1F;
`endif
        chk("t2_ovf0", 64'(ovf[0]), 64'd1);
        chk("t2_res0", 64'(res[5:0]), 64'(exp_l0));
        cycle();
        chk("t2_sticky", 64'(ovf_sticky), 64'd1);

        // Absolute difference overflow, reverse subtract
        send_one({18'h0, 6'h1F}, {18'h0, 6'h20}, 2'b10);
`ifdef VSUB_SAT_EN
        exp_l0 = 6'h1F;
`else
        exp_l0 = 6'h3F;
`endif
        chk("t3_abs_res0", 64'(res[5:0]), 64'(exp_l0));
        chk("t3_abs_ovf0", 64'(ovf[0]), 64'd1);
        cycle();
        send_one({18'h0, 6'h01}, {18'h0, 6'h04}, 2'b11);
        chk("t3_rsub_res0", 64'(res[5:0]), 64'd3);
        chk("t3_rsub_ovf0", 64'(ovf[0]), 64'd0);
        cycle();

        // Stream of 5 with downstream stall in cycles 2..6
        acc_cnt = 0; out0 = out_cnt; last = -1; stall_acc = -1;
        for (int c = 1; c <= 40 && (acc_cnt < 5 || sb.size() > 0); c++) begin
            out_ready = !(c >= 2 && c <= 6);
            in_valid  = (acc_cnt < 5);
            if (acc_cnt != last) begin
                l = VW'($urandom); e = VW'($urandom); mode = 2'($urandom);
                last = acc_cnt;
            end
            cycle();
            if (c == 6) stall_acc = acc_cnt;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t4_accepted_during_stall", 64'(stall_acc), 64'd2);
        chk("t4_all_accepted", 64'(acc_cnt), 64'd5);
        chk("t4_all_emitted", 64'(out_cnt - out0), 64'd5);
        chk("t4_drained", 64'(sb.size()), 64'd0);

        // Sticky clear vs set in the same cycle
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t5_cleared", 64'(ovf_sticky), 64'd0);
        send_one({18'h0, 6'h20}, {18'h0, 6'h01}, 2'b00);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t5_set_wins", 64'(ovf_sticky), 64'd1);
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t5_lone_clear", 64'(ovf_sticky), 64'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; l = VW'($urandom); e = VW'($urandom); mode = 2'($urandom);
        cycle();
        l = VW'($urandom); e = VW'($urandom); mode = 2'($urandom);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("t6_full_before_reset", 64'(sb.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_res", 64'(res), 64'd0);
        chk("t6_rst_ovf", 64'(ovf), 64'd0);
        sb.delete();
        sticky_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("t6_no_stale", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        send_one(VW'($urandom), VW'($urandom), 2'($urandom));
        cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            clr       = ($urandom_range(7) == 0);
            l = VW'($urandom); e = VW'($urandom); mode = 2'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
        repeat (5) cycle();
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
